// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: monitors a multiplexed 7-segment display bus and rebuilds 4-digit BCD frames.
// Latency: input held from edge E0 -> shadow slot written at E0+1+SETTLE_CYCLES, frame out one edge later.
// Backpressure: none; passive monitor, each completed frame is presented as a one-cycle pulse.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk_i,
    input  logic        r_i,
    input  logic [3:0]  an_i,
    input  logic [6:0]  seg_i,
    input  logic        dp_i,
    input  logic        clr_err_i,
    output logic [15:0] digits_o,
    output logic [3:0]  dps_o,
    output logic        frame_valid_o,
    output logic        bad_seg_o,
    output logic        bad_an_o,
    output logic        timeout_o
);

    localparam int          CW   = $clog2(SETTLE_CYCLES + 1);
    localparam int          TW   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [11:0] IDLE = {4'hF, 7'h7F, 1'b1};

    logic [11:0] s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic [3:0]  seen_q, seen_d;
    logic        pend_q, pend_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  dps_q, dps_d;
    logic        fv_q, to_q, bad_seg_q, bad_an_q;
    logic        bad_seg_d, bad_an_d;

    logic [3:0]  samp_an;
    logic [6:0]  samp_seg;
    logic        samp_dp;
    logic        stable_evt, cap, an_err, seg_err, to_fire;
    logic [3:0]  val;

    assign samp_an  = s2_q[11:8];
    assign samp_seg = s2_q[7:1];
    assign samp_dp  = s2_q[0];

    // Two-flop synchronizer for the whole display bus; idle pattern out of reset.
    always_ff @(posedge clk_i or posedge r_i) begin
        if (r_i) begin
            s1_q <= IDLE;
            s2_q <= IDLE;
        end else begin
            s1_q <= {an_i, seg_i, dp_i};
            s2_q <= s1_q;
        end
    end

    // Settle counter: the incoming sample (s1) is compared with the current one (s2).
    always_comb begin
        cnt_d = cnt_q;
        if (s1_q != s2_q) begin
            cnt_d = '0;
        end else if (cnt_q < CW'(SETTLE_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign stable_evt = (s1_q == s2_q) && (cnt_q == CW'(SETTLE_CYCLES - 1));
    assign cap        = stable_evt && $onehot(~samp_an);
    assign an_err     = stable_evt && !$onehot0(~samp_an);

    // Active-low segment pattern back to a digit value; blank maps to F, garbage to E.
    always_comb begin
        val     = 4'hE;
        seg_err = 1'b0;
        case (samp_seg)
            7'h40: val = 4'd0;
            7'h79: val = 4'd1;
            7'h24: val = 4'd2;
            7'h30: val = 4'd3;
            7'h19: val = 4'd4;
            7'h12: val = 4'd5;
            7'h02: val = 4'd6;
            7'h78: val = 4'd7;
            7'h00: val = 4'd8;
            7'h10: val = 4'd9;
            7'h7F: val = 4'hF;
            default: seg_err = cap;
        endcase
    end

    // Capture, frame assembly, timeout and sticky error next-state.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        seen_d      = seen_q;
        digits_d    = digits_q;
        dps_d       = dps_q;
        to_fire     = !cap && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
        tcnt_d      = (cap || to_fire) ? '0 : tcnt_q + TW'(1);
        if (pend_q) begin
            digits_d = shadow_q;
            dps_d    = shadow_dp_q;
        end
        if (pend_q || to_fire) begin
            seen_d = 4'h0;
        end
        if (cap) begin
            for (int i = 0; i < 4; i++) begin
                if (!samp_an[i]) begin
                    shadow_d[4*i +: 4] = val;
                    shadow_dp_d[i]     = ~samp_dp;
                    seen_d[i]          = 1'b1;
                end
            end
        end
        pend_d    = cap && (seen_d == 4'hF);
        bad_seg_d = (bad_seg_q && !clr_err_i) || seg_err;
        bad_an_d  = (bad_an_q && !clr_err_i) || an_err;
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or posedge r_i) begin
        if (r_i) begin
            cnt_q       <= '0;
            tcnt_q      <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            seen_q      <= '0;
            pend_q      <= 1'b0;
            digits_q    <= '0;
            dps_q       <= '0;
            fv_q        <= 1'b0;
            to_q        <= 1'b0;
            bad_seg_q   <= 1'b0;
            bad_an_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            seen_q      <= seen_d;
            pend_q      <= pend_d;
            digits_q    <= digits_d;
            dps_q       <= dps_d;
            fv_q        <= pend_q;
            to_q        <= to_fire;
            bad_seg_q   <= bad_seg_d;
            bad_an_q    <= bad_an_d;
        end
    end

    assign digits_o      = digits_q;
    assign dps_o         = dps_q;
    assign frame_valid_o = fv_q;
    assign bad_seg_o     = bad_seg_q;
    assign bad_an_o      = bad_an_q;
    assign timeout_o     = to_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios followed by random display traffic.
// Every cycle the outputs are compared against a stream-level reference model.
// The model works from the raw input history rather than the synchronizer/counter structure.
module tb_seg_scan_decoder;

    localparam int          SETTLE = 4;
    localparam int          TO     = 64;
    localparam logic [11:0] IDLE   = 12'hFFF;

    logic        clk_i = 1'b0;
    logic        r_i = 1'b1;
    logic [3:0]  an_i = 4'hF;
    logic [6:0]  seg_i = 7'h7F;
    logic        dp_i = 1'b1;
    logic        clr_err_i = 1'b0;
    logic [15:0] digits_o;
    logic [3:0]  dps_o;
    logic        frame_valid_o, bad_seg_o, bad_an_o, timeout_o;

    seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .r_i(r_i), .an_i(an_i), .seg_i(seg_i), .dp_i(dp_i),
        .clr_err_i(clr_err_i), .digits_o(digits_o), .dps_o(dps_o),
        .frame_valid_o(frame_valid_o), .bad_seg_o(bad_seg_o), .bad_an_o(bad_an_o),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int n_fv  = 0;
    int n_to  = 0;

    logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference model state
    logic [11:0] hist[$];
    logic [15:0] m_shadow, m_digits;
    logic [3:0]  m_sdp, m_dps, m_seen;
    logic        m_fv, m_to, m_bseg, m_ban, m_pend;
    int          m_idle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_decode(input logic [6:0] s, output logic err);
        err = 1'b0;
        if (s == 7'h7F) return 4'hF;
        for (int i = 0; i < 10; i++)
            if (codes[i] == s) return 4'(i);
        err = 1'b1;
        return 4'hE;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(IDLE);
        hist.push_back(IDLE);
        m_shadow = '0; m_digits = '0; m_sdp = '0; m_dps = '0; m_seen = '0;
        m_fv = 0; m_to = 0; m_bseg = 0; m_ban = 0; m_pend = 0; m_idle = 0;
    endtask

    // One clock edge: v is the bus value present at this edge, c the clr_err level.
    task automatic model_edge(input logic [11:0] v, input logic c);
        int run, lows, slot;
        logic [11:0] last;
        logic stable, cap, to_fire, serr, aerr;
        logic [3:0] val;
        // Frame emission uses the shadow as it stood before this edge.
        m_fv = m_pend;
        if (m_pend) begin
            m_digits = m_shadow;
            m_dps    = m_sdp;
        end
        // A pattern is accepted when the input was identical for exactly SETTLE+1 edges.
        last = hist[hist.size()-1];
        run = 1;
        for (int i = hist.size() - 2; i >= 0; i--) begin
            if (hist[i] == last) run++;
            else break;
        end
        stable = (run == SETTLE + 1);
        lows = 0; slot = 0;
        for (int i = 0; i < 4; i++)
            if (!last[8+i]) begin lows++; slot = i; end
        cap  = stable && (lows == 1);
        aerr = stable && (lows >= 2);
        to_fire = !cap && (m_idle == TO - 1);
        m_to   = to_fire;
        m_idle = (cap || to_fire) ? 0 : m_idle + 1;
        if (m_pend || to_fire) m_seen = 4'h0;
        serr = 1'b0;
        if (cap) begin
            val = m_decode(last[7:1], serr);
            m_shadow[4*slot +: 4] = val;
            m_sdp[slot]  = ~last[0];
            m_seen[slot] = 1'b1;
        end
        m_pend = cap && (m_seen == 4'hF);
        m_bseg = (m_bseg && !c) || serr;
        m_ban  = (m_ban && !c) || aerr;
        hist.push_back(v);
        if (hist.size() > SETTLE + 2) void'(hist.pop_front());
    endtask

    task automatic tick();
        logic [11:0] v;
        logic rr, c;
        v  = {an_i, seg_i, dp_i};
        rr = r_i;
        c  = clr_err_i;
        @(posedge clk_i);
        if (rr) model_reset();
        else    model_edge(v, c);
        @(negedge clk_i);
        if (frame_valid_o) n_fv++;
        if (timeout_o)     n_to++;
        check("digits",  32'(digits_o),      32'(m_digits));
        check("dps",     32'(dps_o),         32'(m_dps));
        check("fvalid",  32'(frame_valid_o), 32'(m_fv));
        check("timeout", 32'(timeout_o),     32'(m_to));
        check("bad_seg", 32'(bad_seg_o),     32'(m_bseg));
        check("bad_an",  32'(bad_an_o),      32'(m_ban));
        check("shadow",  32'(dut.shadow_q),  32'(m_shadow));
        check("seen",    32'(dut.seen_q),    32'(m_seen));
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        an_i = a; seg_i = s; dp_i = d;
        repeat (n) tick();
    endtask

    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
        hold(4'b1110, s0, 1'b1, 8); hold(4'hF, 7'h7F, 1'b1, 2);
        hold(4'b1101, s1, 1'b1, 8); hold(4'hF, 7'h7F, 1'b1, 2);
        hold(4'b1011, s2, 1'b1, 8); hold(4'hF, 7'h7F, 1'b1, 2);
        hold(4'b0111, s3, 1'b1, 8); hold(4'hF, 7'h7F, 1'b1, 2);
    endtask

    initial begin
        int lat;
        logic [3:0] a;
        logic [6:0] s;
        model_reset();
        r_i = 1'b1;
        repeat (3) tick();
        check("rst_digits", 32'(digits_o), 32'h0);
        check("rst_flags", 32'({frame_valid_o, bad_seg_o, bad_an_o, timeout_o, dps_o}), 32'h0);
        r_i = 1'b0;
        hold(4'hF, 7'h7F, 1'b1, 4);

        // 1: full scan of 1,2,3,4
        n_fv = 0;
        scan4(7'h79, 7'h24, 7'h30, 7'h19);
        hold(4'hF, 7'h7F, 1'b1, 3);
        check("t1_frames", 32'(n_fv), 32'd1);
        check("t1_digits", 32'(digits_o), 32'h4321);
        check("t1_dps", 32'(dps_o), 32'h0);

        // 2: capture latency, then a pattern too short to settle
        hold(4'b1110, 7'h40, 1'b1, 8);
        hold(4'hF, 7'h7F, 1'b1, 2);
        an_i = 4'b1110; seg_i = 7'h79; dp_i = 1'b1;
        lat = -1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (lat < 0 && dut.shadow_q[3:0] == 4'd1) lat = j - 1;
        end
        check("t2_latency", 32'(lat), 32'(SETTLE + 1));
        hold(4'hF, 7'h7F, 1'b1, 2);
        hold(4'b1101, 7'h24, 1'b1, 3);
        hold(4'hF, 7'h7F, 1'b1, 6);
        check("t2_short_seen", 32'(dut.seen_q), 32'h1);

        // 3: two anodes low
        hold(4'b1100, 7'h79, 1'b1, 8);
        hold(4'hF, 7'h7F, 1'b1, 2);
        check("t3_bad_an", 32'(bad_an_o), 32'h1);
        check("t3_seen", 32'(dut.seen_q), 32'h1);
        clr_err_i = 1'b1; tick(); clr_err_i = 1'b0; tick();
        check("t3_cleared", 32'(bad_an_o), 32'h0);

        // 4: invalid segment pattern and blank
        hold(4'b1011, 7'h36, 1'b1, 8);
        hold(4'hF, 7'h7F, 1'b1, 2);
        check("t4_slot2", 32'(dut.shadow_q[11:8]), 32'hE);
        check("t4_bad_seg", 32'(bad_seg_o), 32'h1);
        clr_err_i = 1'b1; tick(); clr_err_i = 1'b0;
        hold(4'b1101, 7'h7F, 1'b1, 8);
        hold(4'hF, 7'h7F, 1'b1, 2);
        check("t4_slot1", 32'(dut.shadow_q[7:4]), 32'hF);
        check("t4_blank_flag", 32'(bad_seg_o), 32'h0);

        // 5: partial frame timeout
        hold(4'hF, 7'h7F, 1'b1, 70);
        hold(4'b1110, 7'h79, 1'b1, 8); hold(4'hF, 7'h7F, 1'b1, 2);
        hold(4'b1101, 7'h24, 1'b1, 8); hold(4'hF, 7'h7F, 1'b1, 2);
        n_to = 0;
        hold(4'hF, 7'h7F, 1'b1, 66);
        check("t5_timeouts", 32'(n_to), 32'd1);
        check("t5_digits", 32'(digits_o), 32'h4321);
        check("t5_seen", 32'(dut.seen_q), 32'h0);
        n_fv = 0;
        hold(4'b1011, 7'h30, 1'b1, 8); hold(4'hF, 7'h7F, 1'b1, 2);
        hold(4'b0111, 7'h19, 1'b1, 8); hold(4'hF, 7'h7F, 1'b1, 4);
        check("t5_no_frame", 32'(n_fv), 32'd0);

        // 6: reset in mid-frame, then a clean scan of 5,6,7,8
        hold(4'b1110, 7'h12, 1'b1, 8); hold(4'hF, 7'h7F, 1'b1, 2);
        hold(4'b1101, 7'h02, 1'b1, 8); hold(4'hF, 7'h7F, 1'b1, 2);
        hold(4'b1011, 7'h78, 1'b1, 8); hold(4'hF, 7'h7F, 1'b1, 2);
        r_i = 1'b1;
        #1;
        check("t6_rst_async", 32'(digits_o), 32'h0);
        tick(); tick();
        check("t6_rst_outs", 32'({digits_o, dps_o, frame_valid_o, bad_seg_o, bad_an_o, timeout_o}), 32'h0);
        r_i = 1'b0;
        n_fv = 0;
        scan4(7'h12, 7'h02, 7'h78, 7'h00);
        hold(4'hF, 7'h7F, 1'b1, 3);
        check("t6_frames", 32'(n_fv), 32'd1);
        check("t6_digits", 32'(digits_o), 32'h8765);

        // Random display traffic
        for (int k = 0; k < 250; k++) begin
            case ($urandom % 10)
                7:       a = 4'hF;
                8:       a = 4'($urandom);
                default: a = ~(4'b0001 << ($urandom % 4));
            endcase
            s = ($urandom % 5 == 0) ? 7'($urandom) : codes[$urandom % 10];
            clr_err_i = ($urandom % 8 == 0);
            if ($urandom % 60 == 0) begin
                r_i = 1'b1;
                hold(4'hF, 7'h7F, 1'b1, 2);
                r_i = 1'b0;
            end
            hold(a, s, 1'($urandom), int'($urandom_range(1, 9)));
        end
        clr_err_i = 1'b0;
        hold(4'hF, 7'h7F, 1'b1, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
